fp32_dot_sequencer: RTL and testbench

//   Sequences a shared combinational FP32 multiply-add unit (delta = alpha*bravo + acc)
//   to compute dot products of length LEN over a streamed operand-pair interface.

---
 rtl/fp32_dot_sequencer.sv | 114 +++++++++++
 tb/tb_fp32_dot_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_dot_sequencer.sv
// Drives a shared combinational FP32 multiply-add unit to accumulate a LEN-element dot product.
// Each element takes 1+SETTLE_CYC cycles; the result is held on RES_* until the consumer accepts it.
module fp32_dot_sequencer #(
    parameter int LEN_W      = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic             CLK_I,
    input  logic             RSTL_I,
    input  logic             START_I,
    input  logic [LEN_W-1:0] LEN_I,
    input  logic             OPND_VALID_I,
    output logic             OPND_READY_O,
    input  logic [31:0]      ALPHA_I,
    input  logic [31:0]      BRAVO_I,
    output logic [31:0]      MAC_ALPHA_O,
    output logic [31:0]      MAC_BRAVO_O,
    output logic [31:0]      MAC_ACC_O,
    input  logic [31:0]      MAC_DELTA_I,
    output logic             RES_VALID_O,
    input  logic             RES_READY_I,
    output logic [31:0]      RES_DATA_O,
    output logic             BUSY_O
);
    localparam int WAIT_W = $clog2(SETTLE_CYC) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SETTLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       mac_alpha_q, mac_alpha_d;
    logic [31:0]       mac_bravo_q, mac_bravo_d;
    logic [31:0]       mac_acc_q, mac_acc_d;

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            wait_cnt_q  <= '0;
            acc_q       <= '0;
            mac_alpha_q <= '0;
            mac_bravo_q <= '0;
            mac_acc_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            acc_q       <= acc_d;
            mac_alpha_q <= mac_alpha_d;
            mac_bravo_q <= mac_bravo_d;
            mac_acc_q   <= mac_acc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wait_cnt_d  = wait_cnt_q;
        acc_d       = acc_q;
        mac_alpha_d = mac_alpha_q;
        mac_bravo_d = mac_bravo_q;
        mac_acc_d   = mac_acc_q;
        case (state_q)
            IDLE: begin
                if (START_I) begin
                    len_d   = LEN_I;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (LEN_I == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (OPND_VALID_I) begin
                    mac_alpha_d = ALPHA_I;
                    mac_bravo_d = BRAVO_I;
                    mac_acc_d   = acc_q;
                    wait_cnt_d  = '0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                // The unit's inputs have been stable long enough; fold its output back in.
                if (wait_cnt_q == WAIT_LAST) begin
                    acc_d   = MAC_DELTA_I;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                if (RES_READY_I) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign OPND_READY_O = (state_q == FETCH);
    assign RES_VALID_O  = (state_q == DONE);
    assign RES_DATA_O   = (state_q == DONE) ? acc_q : '0;
    assign BUSY_O       = (state_q != IDLE);
    assign MAC_ALPHA_O  = mac_alpha_q;
    assign MAC_BRAVO_O  = mac_bravo_q;
    assign MAC_ACC_O    = mac_acc_q;
endmodule

// File: tb/tb_fp32_dot_sequencer.sv
// Bench for fp32_dot_sequencer: a behavioural FP32 multiply-add unit on the MAC ports,
// and a result scoreboard fed by the driver and drained by an independent monitor.
module tb_fp32_dot_sequencer;
    localparam int S = 4;

    logic        clk, rstl;
    logic        start;
    logic [7:0]  len;
    logic        opnd_valid, opnd_ready;
    logic [31:0] alpha, bravo;
    logic [31:0] mac_alpha, mac_bravo, mac_acc, mac_delta;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] dat;
        int          lat;
    } exp_t;
    exp_t exp_q[$];
    logic [31:0] op_a[$];
    logic [31:0] op_b[$];

    fp32_dot_sequencer #(.LEN_W(8), .SETTLE_CYC(S)) dut (
        .CLK_I(clk), .RSTL_I(rstl), .START_I(start), .LEN_I(len),
        .OPND_VALID_I(opnd_valid), .OPND_READY_O(opnd_ready),
        .ALPHA_I(alpha), .BRAVO_I(bravo),
        .MAC_ALPHA_O(mac_alpha), .MAC_BRAVO_O(mac_bravo), .MAC_ACC_O(mac_acc),
        .MAC_DELTA_I(mac_delta),
        .RES_VALID_O(res_valid), .RES_READY_I(res_ready), .RES_DATA_O(res_data),
        .BUSY_O(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real fp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d[63]    = f[31];
        d[62:52] = (f[30:23] == 8'hff) ? 11'h7ff : (11'(f[30:23]) + 11'd896);
        d[51:0]  = {f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 0) return {d[63], 31'd0};
        if (e == 2047) return {d[63], 8'hff, d[51:29]};
        e = e - 896;
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hff, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Combinational multiply-add unit under the sequencer's control.
    assign mac_delta = real_to_fp(fp_to_real(mac_alpha) * fp_to_real(mac_bravo) + fp_to_real(mac_acc));

    function automatic logic [31:0] int_to_fp(input int v);
        logic [31:0] m;
        logic [31:0] sh;
        int          p;
        if (v == 0) return 32'd0;
        m = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        sh = m << (23 - p);
        return {(v < 0), 8'(127 + p), sh[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(opnd_ready), 32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_data"},  res_data, 32'd0);
        check({tag, "_alpha"}, mac_alpha, 32'd0);
        check({tag, "_bravo"}, mac_bravo, 32'd0);
        check({tag, "_acc"},   mac_acc, 32'd0);
    endtask

    // Monitor: checks stability while stalled, latency of first valid, and data on handshake.
    initial begin
        bit          seen;
        int          first_cyc;
        logic [31:0] first_dat;
        exp_t        e;
        seen = 0;
        first_cyc = 0;
        first_dat = '0;
        forever begin
            @(negedge clk);
            if (!rstl) begin
                seen = 0;
            end else if (res_valid) begin
                if (!seen) begin
                    seen = 1;
                    first_cyc = cyc;
                    first_dat = res_data;
                end else begin
                    check("res_stable", res_data, first_dat);
                end
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", res_data, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", res_data, e.dat);
                        if (e.lat >= 0) check("res_latency", 32'(first_cyc), 32'(e.lat));
                    end
                    seen = 0;
                end
            end
        end
    end

    task automatic wait_rdy();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (opnd_ready) return;
        end
        check("opnd_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (res_valid) return;
        end
        check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(output bit saw_rdy);
        saw_rdy = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (opnd_ready) saw_rdy = 1;
            if (!busy) return;
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic feed(input logic [31:0] a, input logic [31:0] b, input int gap);
        if (gap > 0) begin
            wait_rdy();
            repeat (gap) @(posedge clk);
            #1;
        end
        opnd_valid = 1'b1;
        alpha = a;
        bravo = b;
        wait_rdy();
        @(posedge clk);
        #1;
        opnd_valid = 1'b0;
    endtask

    task automatic run_vector(input int n, input logic [31:0] exp, input int gap, input int hold);
        exp_t e;
        bit   saw;
        e.dat = exp;
        e.lat = (gap == 0) ? cyc + 1 + n * (1 + S) : -1;
        exp_q.push_back(e);
        res_ready = (hold == 0);
        len = 8'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            feed(op_a[i], op_b[i], gap);
            if (hold > 0 && i == 0) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        if (hold > 0) begin
            wait_valid();
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                start = (k == 3);
            end
            start = 1'b0;
            res_ready = 1'b1;
        end
        wait_idle(saw);
        if (n == 0) check("len0_no_opnd_ready", 32'(saw), 32'd0);
        if (hold > 0) begin
            repeat (3) @(posedge clk);
            #1;
            check("start_ignored_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic load_rand(input int n, output logic [31:0] exp);
        int a, b, sum;
        op_a.delete();
        op_b.delete();
        sum = 0;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(100)) - 50;
            b = int'($urandom_range(100)) - 50;
            sum += a * b;
            op_a.push_back(int_to_fp(a));
            op_b.push_back(int_to_fp(b));
        end
        exp = int_to_fp(sum);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ex1, ex2;
        exp_t        e;
        bit          saw;
        rstl = 1'b0;
        start = 1'b0;
        len = '0;
        opnd_valid = 1'b0;
        alpha = '0;
        bravo = '0;
        res_ready = 1'b1;
        #2;
        check_all_zero("reset");
        #10;
        rstl = 1'b1;
        @(posedge clk);
        #1;

        op_a = '{32'hBF000000};
        op_b = '{32'h3F400000};
        run_vector(1, 32'hBEC00000, 0, 0);

        op_a = '{32'h3F800000, 32'h40000000, 32'h40400000};
        op_b = '{32'h40800000, 32'h40A00000, 32'h40C00000};
        run_vector(3, 32'h42000000, 0, 0);

        run_vector(0, 32'h00000000, 0, 0);

        op_a = '{32'h40000000, 32'hC0400000};
        op_b = '{32'h40A00000, 32'h40E00000};
        run_vector(2, 32'hC1300000, 5, 10);

        // Abort a LEN=3 run in the settle phase of its second element.
        op_a = '{32'h3F800000, 32'h40000000, 32'h40400000};
        op_b = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        len = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed(op_a[0], op_b[0], 0);
        feed(op_a[1], op_b[1], 0);
        @(posedge clk);
        #1;
        rstl = 1'b0;
        #1;
        check_all_zero("async_reset");
        #20;
        rstl = 1'b1;
        @(posedge clk);
        #1;
        op_a = '{32'h40400000};
        op_b = '{32'h40800000};
        run_vector(1, 32'h41400000, 0, 0);

        // START held high across DONE->IDLE: second run must start from acc=0.
        load_rand(3, ex1);
        e.dat = ex1;
        e.lat = -1;
        exp_q.push_back(e);
        res_ready = 1'b1;
        len = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) feed(op_a[i], op_b[i], 0);
        load_rand(2, ex2);
        e.dat = ex2;
        exp_q.push_back(e);
        len = 8'd2;
        wait_valid();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_restarted", 32'(busy), 32'd1);
        for (int i = 0; i < 2; i++) feed(op_a[i], op_b[i], 0);
        wait_idle(saw);

        for (int t = 0; t < 20; t++) begin
            int n;
            n = int'($urandom_range(8, 1));
            load_rand(n, ex1);
            run_vector(n, ex1, ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0,
                       ($urandom_range(3) == 0) ? int'($urandom_range(6, 2)) : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
